instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the synchronous-read instruction memory (1-cycle read latency, 10-bit word address, 32-bit words). Owns the PC and drives the memory address. Pairs each returned word with its PC and valid flag for the decode stage. Supports decode stall (hold current instruction) and a branch/jump redirect that kills the wrong-path word.

Parameters:
ADDR_W, 10, word-address width; PC wraps modulo 2^ADDR_W.
DATA_W, 32, instruction width.
RESET_PC, 0, first address fetched after reset.
NOP_INSTR, 32'b0, value driven on if_instr when if_valid=0.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  ADDR_W  word address to instruction memory; combinational mux, see Behaviour.
imem_data  in  DATA_W  registered read data from memory (word addressed in previous cycle).
stall  in  1  decode cannot accept; hold current if_instr/if_pc.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  ADDR_W  target word address.
if_instr  out  DATA_W  instruction to decode.
if_pc  out  ADDR_W  word address of if_instr.
if_valid  out  1  if_instr is a real, non-killed instruction.

Behaviour:
- Clock clk; reset rst is asynchronous, active-high. Priority in every cycle: rst > redirect_valid > stall > normal advance.
- State: pc_q (next address to request), req_pc_q (address requested last cycle), FSM with states S_FILL and S_RUN.
- Reset values:
  - pc_q=RESET_PC, req_pc_q=RESET_PC, state=S_FILL.
  - Outputs: imem_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC.
- S_FILL: the memory output is stale, so if_valid=0 and stall is ignored. imem_addr=pc_q. At the next edge: req_pc_q<=pc_q, pc_q<=pc_q+1, state goes to S_RUN.
- S_RUN outputs: if_valid = !redirect_valid; if_instr = if_valid ? imem_data : NOP_INSTR; if_pc = req_pc_q.
- S_RUN normal advance: imem_addr=pc_q. At the edge: req_pc_q<=pc_q, pc_q<=pc_q+1.
- S_RUN stall (without redirect):
  - imem_addr=req_pc_q, so the memory re-reads the word currently presented.
  - pc_q and req_pc_q hold.
  - if_instr/if_pc stay stable for every stalled cycle.
- Redirect (either state):
  - imem_addr=redirect_pc; if_valid=0 this cycle.
  - At the edge: req_pc_q<=redirect_pc, pc_q<=redirect_pc+1, state goes to S_RUN.
  - The target word appears with if_valid=1 on the next cycle. Redirect cost is one bubble.
- Wrap-around: pc (2^ADDR_W - 1)+1 -> 0, with no flag. A redirect_pc of all-ones wraps the same way.
- Throughput: 1 instruction/cycle without stall or redirect. The first valid instruction appears 1 cycle after reset deasserts.
- Reset asserted mid-operation: immediate return to the reset values. No in-flight word is ever reported valid after reset.
- if_instr is a combinational pass-through of imem_data (no extra register). Decode registers it.

Optional Feature:
- IF_PERF_CNT_EN defined: adds three outputs, each 32 bits, reset 0, wrapping.
  - perf_fetch_cnt: +1 each cycle with if_valid && !stall.
  - perf_stall_cnt: +1 each cycle with if_valid && stall.
  - perf_redirect_cnt: +1 each cycle with redirect_valid.
- Undefined: these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package fetch_pkg holds ADDR_W, DATA_W, NOP_INSTR, and the FSM state typedef (S_FILL, S_RUN).
- Optional sub-module if_perf_counters contains the three counters, instantiated only under IF_PERF_CNT_EN.
- PC/FSM logic stays in instruction_fetch.

Test Plan:
- Reset release with memory holding M[0]=0, M[1]=0x3401C000: cycle 1 shows if_valid=1, if_pc=0, if_instr=0; cycle 2 shows if_pc=1, if_instr=0x3401C000; imem_addr sequence 0,1,2,3.
- Stall held 3 cycles while if_pc=6: if_pc=6 and if_instr=M[6] are stable all 3 cycles; imem_addr=6 during stall; after release, if_pc=7 next.
- Redirect to 28 while if_pc=12: that cycle if_valid=0 and imem_addr=28; next cycle if_pc=28, if_instr=M[28]; then 29.
- Redirect and stall asserted together: redirect wins (same as previous scenario). Stall during S_FILL is ignored.
- PC wrap: redirect to 1023 yields if_pc 1023 then 0, both valid.
- Async rst pulsed mid-cycle during a stall: outputs are immediately if_valid=0, imem_addr=0. Under IF_PERF_CNT_EN, all counters read 0; after 10 free-running cycles, perf_fetch_cnt=9.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents:
//   ADDR_W        - width of a word address; the PC wraps modulo 2^ADDR_W
//   DATA_W        - width of an instruction word
//   NOP_INSTR     - word driven to decode whenever no valid instruction is presented
//   fetch_state_t - fetch FSM states
//     S_FILL : memory output is stale (first cycle after reset)
//     S_RUN  : memory output belongs to req_pc_q
package fetch_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] NOP_INSTR = '0;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/if_perf_counters.sv
// Fetch-stage performance counters. Built only when IF_PERF_CNT_EN is defined.
// All three counters are 32 bits wide, are cleared by reset and wrap silently.
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   if_valid           - a valid instruction is being presented to decode
//   stall              - decode is not accepting this cycle
//   redirect_valid     - a branch/jump redirect is taken this cycle
//   perf_fetch_cnt     - cycles in which a valid instruction was accepted
//   perf_stall_cnt     - cycles in which a valid instruction was held by stall
//   perf_redirect_cnt  - cycles in which a redirect was taken
module if_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt    <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (if_valid && !stall) perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
            if (if_valid && stall)  perf_stall_cnt    <= perf_stall_cnt + 32'd1;
            if (redirect_valid)     perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. It sits in front of a synchronous-read instruction
// memory with one cycle of read latency. The stage owns the PC, drives the
// memory address, and pairs each returned word with its PC and a valid flag.
// Optional feature: defining IF_PERF_CNT_EN adds the three perf_* counters.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   imem_addr       - combinational word address presented to the memory
//   imem_data       - registered read data (word addressed on the previous cycle)
//   stall           - decode is not accepting; hold the current if_instr/if_pc
//   redirect_valid  - a branch/jump redirect is taken this cycle
//   redirect_pc     - target word address of the redirect
//   if_instr        - instruction to decode (pass-through of imem_data, or NOP)
//   if_pc           - word address of if_instr
//   if_valid        - if_instr is a real, non-killed instruction
//   perf_*_cnt      - performance counters (IF_PERF_CNT_EN builds only)
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);
    localparam logic [ADDR_W-1:0] PC_INC = 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;          // next address to request
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;  // address whose data is on imem_data

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        imem_addr = pc_q;
        if_valid  = 1'b0;
        if_pc     = req_pc_q;

        if (redirect_valid) begin
            // Kill whatever the memory returns this cycle. The target is read
            // now, so it is presented on the very next cycle.
            imem_addr = redirect_pc;
            req_pc_d  = redirect_pc;
            pc_d      = redirect_pc + PC_INC;
            state_d   = S_RUN;
        end else if (state_q == S_FILL) begin
            // Memory output is stale here, so stall has nothing to hold.
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_INC;
            state_d  = S_RUN;
        end else begin
            if_valid = 1'b1;
            if (stall) begin
                // Re-read the presented word so imem_data stays stable.
                imem_addr = req_pc_q;
            end else begin
                req_pc_d = pc_q;
                pc_d     = pc_q + PC_INC;
            end
        end
    end

    assign if_instr = if_valid ? imem_data : NOP_INSTR;

`ifdef IF_PERF_CNT_EN
    if_perf_counters u_perf (
        .clk               (clk),
        .rst               (rst),
        .if_valid          (if_valid),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );
`endif
endmodule
